pwm_duty_ramp: RTL and testbench



---
 rtl/pwm_duty_pkg.sv | 15 +
 rtl/pwm_period_tick.sv | 30 +++
 rtl/pwm_duty_ramp.sv | 134 +++++++++++++
 tb/tb_pwm_duty_ramp.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_duty_pkg.sv
// Shared types and constants for the PWM duty soft-start sequencer.
package pwm_duty_pkg;

    // Default duty width; matches the 4-bit PWM generator's pulse_width.
    localparam int DEF_WIDTH_W = 4;

    // Width of the per-step period counter (STEP_PERIODS up to 255).
    localparam int STEP_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period tick: synchronises the asynchronous clk_500Hz reference into
// clk_50MHz and emits a one-cycle pulse per rising edge. Reusable by any
// stage that needs to lock to the PWM period.
module pwm_period_tick (
    input  logic clk_50MHz,
    input  logic rst_n,
    input  logic clk_500Hz,
    output logic tick
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Two-flop synchroniser followed by an edge-detect flop.
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= clk_500Hz;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign tick = r_s2 & ~r_s3;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start duty sequencer feeding the PWM generator's pulse_width.
// Accepts a target duty over valid/ready, then walks pulse_width toward it
// by STEP_SIZE once every STEP_PERIODS PWM periods.
// Optional build macro PWM_DUTY_RETARGET_EN: keeps target_ready high while
// ramping so a new target can redirect a ramp in flight.
module pwm_duty_ramp
    import pwm_duty_pkg::*;
#(
    parameter int WIDTH_W      = DEF_WIDTH_W,
    parameter int STEP_SIZE    = 1,
    parameter int STEP_PERIODS = 1
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic               clk_500Hz,
    input  logic [WIDTH_W-1:0] target_width,
    input  logic               target_valid,
    output logic               target_ready,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic               at_target,
    output logic               busy
);

    localparam logic [WIDTH_W:0] STEP_X = STEP_SIZE[WIDTH_W:0];
    localparam int               LAST_I = STEP_PERIODS - 1;
    localparam logic [STEP_CNT_W-1:0] CNT_LAST = LAST_I[STEP_CNT_W-1:0];

    ramp_state_t               r_state;
    ramp_state_t               w_state_nxt;
    logic [WIDTH_W-1:0]        r_pw;
    logic [WIDTH_W-1:0]        r_tgt;
    logic [STEP_CNT_W-1:0]     r_cnt;
    logic [WIDTH_W-1:0]        w_pw_nxt;
    logic [WIDTH_W-1:0]        w_tgt_nxt;
    logic [STEP_CNT_W-1:0]     w_cnt_nxt;
    logic [WIDTH_W-1:0]        w_step_pw;
    logic [WIDTH_W:0]          w_pw_x;
    logic [WIDTH_W:0]          w_tgt_x;
    logic [WIDTH_W:0]          w_sum;
    logic [WIDTH_W:0]          w_dif;
    logic                      w_tick;
    logic                      w_ready;
    logic                      w_xfer;
    logic                      w_step;

    pwm_period_tick u_tick (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .clk_500Hz (clk_500Hz),
        .tick      (w_tick)
    );

`ifdef PWM_DUTY_RETARGET_EN
    assign w_ready = 1'b1;
`else
    assign w_ready = (r_state == IDLE);
`endif

    assign w_xfer = target_valid & w_ready;
    assign w_step = (r_state == RAMP) & w_tick & (r_cnt == CNT_LAST);

    // One saturating step toward the latched target, one bit wider so the
    // add/subtract can never wrap past it.
    always_comb begin
        w_pw_x    = {1'b0, r_pw};
        w_tgt_x   = {1'b0, r_tgt};
        w_sum     = w_pw_x + STEP_X;
        w_dif     = w_pw_x - STEP_X;
        w_step_pw = r_pw;
        if (w_tgt_x > w_pw_x) begin
            w_step_pw = (w_sum >= w_tgt_x) ? r_tgt : w_sum[WIDTH_W-1:0];
        end else if (w_tgt_x < w_pw_x) begin
            w_step_pw = (w_pw_x <= w_tgt_x + STEP_X) ? r_tgt : w_dif[WIDTH_W-1:0];
        end
    end

    // Next-state logic: handshake, period counting and stepping.
    always_comb begin
        w_state_nxt = r_state;
        w_pw_nxt    = r_pw;
        w_tgt_nxt   = r_tgt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_tgt_nxt = target_width;
                    if (target_width != r_pw) begin
                        w_state_nxt = RAMP;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            RAMP: begin
                if (w_tick) begin
                    w_cnt_nxt = w_step ? '0 : r_cnt + 1'b1;
                end
                // A coincident step still aims at the old target.
                if (w_step) begin
                    w_pw_nxt = w_step_pw;
                end
`ifdef PWM_DUTY_RETARGET_EN
                if (w_xfer) begin
                    w_tgt_nxt = target_width;
                end
`endif
                if (w_pw_nxt == w_tgt_nxt) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, duty, target and counter registers.
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pw    <= '0;
            r_tgt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pw    <= w_pw_nxt;
            r_tgt   <= w_tgt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign target_ready = w_ready;
    assign pulse_width  = r_pw;
    assign at_target    = (r_pw == r_tgt);
    assign busy         = (r_state == RAMP);

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: two instances (default step, and STEP_SIZE=3 /
// STEP_PERIODS=2) share clock, reset and clk_500Hz. A period-level model
// predicts duty, busy, ready and at_target after every clk_50MHz edge.
module tb_pwm_duty_ramp;

    logic       clk_50MHz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       clk_500Hz = 1'b0;
    logic [3:0] tw0 = '0, tw1 = '0;
    logic       tv0 = 1'b0, tv1 = 1'b0;
    logic       rdy0, rdy1, at0, at1, busy0, busy1;
    logic [3:0] pw0, pw1;

    int errs = 0;
    int chks = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    pwm_duty_ramp #(.WIDTH_W(4), .STEP_SIZE(1), .STEP_PERIODS(1)) u_dut0 (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .clk_500Hz(clk_500Hz),
        .target_width(tw0), .target_valid(tv0), .target_ready(rdy0),
        .pulse_width(pw0), .at_target(at0), .busy(busy0));

    pwm_duty_ramp #(.WIDTH_W(4), .STEP_SIZE(3), .STEP_PERIODS(2)) u_dut1 (
        .clk_50MHz(clk_50MHz), .rst_n(rst_n), .clk_500Hz(clk_500Hz),
        .target_width(tw1), .target_valid(tv1), .target_ready(rdy1),
        .pulse_width(pw1), .at_target(at1), .busy(busy1));

`ifdef PWM_DUTY_RETARGET_EN
    localparam bit RETGT = 1'b1;
`else
    localparam bit RETGT = 1'b0;
`endif

    // Reference model state per instance.
    int m_pw[2]   = '{0, 0};
    int m_tgt[2]  = '{0, 0};
    int m_per[2]  = '{0, 0};
    bit m_ramp[2] = '{0, 0};
    int m_ss[2]   = '{1, 3};
    int m_sp[2]   = '{1, 2};
    int g_cnt     = 5;
    int pend      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One PWM-period-level update: count periods, step with clamping at the
    // target, accept a request when ready.
    task automatic model_edge(input int i, input bit tk, input bit v, input int t);
        bit was;
        bit rdy;
        was = m_ramp[i];
        rdy = RETGT ? 1'b1 : !was;
        if (was && tk) begin
            m_per[i]++;
            if (m_per[i] == m_sp[i]) begin
                m_per[i] = 0;
                if (m_tgt[i] > m_pw[i])
                    m_pw[i] = (m_pw[i] + m_ss[i] > m_tgt[i]) ? m_tgt[i] : m_pw[i] + m_ss[i];
                else if (m_tgt[i] < m_pw[i])
                    m_pw[i] = (m_pw[i] - m_ss[i] < m_tgt[i]) ? m_tgt[i] : m_pw[i] - m_ss[i];
            end
        end
        if (v && rdy) begin
            m_tgt[i] = t;
            if (!was && t != m_pw[i]) begin
                m_ramp[i] = 1'b1;
                m_per[i]  = 0;
            end
        end
        if (was && m_pw[i] == m_tgt[i]) m_ramp[i] = 1'b0;
    endtask

    task automatic check_all();
        chk("pw0", 32'(pw0), 32'(m_pw[0]));
        chk("busy0", 32'(busy0), 32'(m_ramp[0]));
        chk("rdy0", 32'(rdy0), 32'(RETGT | !m_ramp[0]));
        chk("at0", 32'(at0), 32'(m_pw[0] == m_tgt[0]));
        chk("pw1", 32'(pw1), 32'(m_pw[1]));
        chk("busy1", 32'(busy1), 32'(m_ramp[1]));
        chk("rdy1", 32'(rdy1), 32'(RETGT | !m_ramp[1]));
        chk("at1", 32'(at1), 32'(m_pw[1] == m_tgt[1]));
    endtask

    // One clk_50MHz cycle: drive at negedge (clk_500Hz free-runs with
    // random high/low lengths), update model after posedge, compare.
    task automatic cycle(input bit v0, input int t0, input bit v1, input int t1, input bit rs);
        bit rose;
        bit tk;
        @(negedge clk_50MHz);
        rose = 1'b0;
        if (g_cnt == 0) begin
            clk_500Hz = ~clk_500Hz;
            rose      = clk_500Hz;
            g_cnt     = $urandom_range(4, 10);
        end else begin
            g_cnt--;
        end
        rst_n = rs;
        tv0 = v0; tw0 = 4'(t0);
        tv1 = v1; tw1 = 4'(t1);
        @(posedge clk_50MHz);
        #1;
        if (!rs) begin
            // A reference held high through reset looks like a fresh rise.
            pend = clk_500Hz ? 3 : 0;
            for (int i = 0; i < 2; i++) begin
                m_pw[i] = 0; m_tgt[i] = 0; m_per[i] = 0; m_ramp[i] = 1'b0;
            end
        end else begin
            if (rose) pend = 3;
            tk = (pend == 1);
            if (pend > 0) pend--;
            model_edge(0, tk, v0, t0);
            model_edge(1, tk, v1, t1);
        end
        check_all();
    endtask

    task automatic settle(input int i, input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (!m_ramp[i]) break;
            cycle(0, 0, 0, 0, 1);
        end
        chk($sformatf("settle_busy%0d", i), 32'(i ? busy1 : busy0), 32'd0);
    endtask

    initial begin
        // Reset held with the reference toggling.
        for (int n = 0; n < 25; n++) cycle(0, 0, 0, 0, 0);
        chk("rst_pw0", 32'(pw0), 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd1);
        chk("rst_at0", 32'(at0), 32'd1);
        chk("rst_busy0", 32'(busy0), 32'd0);
        cycle(0, 0, 0, 0, 1);

        // Default ramp 0 -> 4.
        cycle(1, 4, 0, 0, 1);
        chk("ramp4_busy", 32'(busy0), 32'd1);
        chk("ramp4_rdy", 32'(rdy0), 32'(RETGT));
        settle(0, 400);
        chk("ramp4_pw", 32'(pw0), 32'd4);
        chk("ramp4_at", 32'(at0), 32'd1);

        // Coarse step, clamped downward: 12 -> 9 -> 8.
        cycle(0, 0, 1, 12, 1);
        settle(1, 800);
        cycle(0, 0, 1, 8, 1);
        settle(1, 800);
        chk("clamp_pw1", 32'(pw1), 32'd8);

        // Equal-target request is a no-op.
        cycle(1, 15, 0, 0, 1);
        settle(0, 800);
        cycle(1, 15, 0, 0, 1);
        chk("noop_busy", 32'(busy0), 32'd0);
        for (int n = 0; n < 30; n++) cycle(0, 0, 0, 0, 1);
        chk("noop_pw", 32'(pw0), 32'd15);

        // Reset mid-ramp at duty 5.
        cycle(1, 0, 0, 0, 1);
        settle(0, 800);
        cycle(1, 12, 0, 0, 1);
        for (int n = 0; n < 400 && m_pw[0] != 5; n++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("mrst_pw", 32'(pw0), 32'd0);
        chk("mrst_rdy", 32'(rdy0), 32'd1);
        chk("mrst_busy", 32'(busy0), 32'd0);

        // Retarget at duty 5 toward 2 (ignored when the option is off).
        cycle(1, 12, 0, 0, 1);
        for (int n = 0; n < 400 && m_pw[0] != 5; n++) cycle(0, 0, 0, 0, 1);
        cycle(1, 2, 0, 0, 1);
        settle(0, 800);
        chk("retgt_pw", 32'(pw0), RETGT ? 32'd2 : 32'd12);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 15),
                  ($urandom_range(0, 299) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule
